// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register.
// Carries an opaque payload plus valid, debug PC and delay-slot flag between
// two pipeline stages. It advances, holds or inserts a bubble based on the
// global stall vector, squashes on flush, and keeps saturating bubble/hold
// counters for performance debug. All outputs come straight from flops.
module pipe_stage_reg #(
    parameter int                 DATA_W          = 64,
    parameter int                 STALL_W         = 6,
    parameter int                 STAGE           = 2,
    parameter logic [DATA_W-1:0]  NOP_PAYLOAD     = {DATA_W{1'b0}},
    parameter bit                 CLEAR_ON_BUBBLE = 1'b1,
    parameter int                 CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_payload,
    input  logic [31:0]       in_pc,
    input  logic              in_delayslot,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_payload,
    output logic [31:0]       out_pc,
    output logic              out_delayslot,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  hold_cnt
);

    // The downstream stall bit must exist inside the stall vector.
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
        $fatal(1, "pipe_stage_reg: STAGE+1 (%0d) must be below STALL_W (%0d)", STAGE + 1, STALL_W);
    end

    // Clamp the index so an illegal configuration never produces an
    // out-of-range select before the fatal above stops elaboration.
    localparam int UP_IDX = (STAGE < STALL_W) ? STAGE : STALL_W - 1;
    localparam int DN_IDX = (STAGE + 1 < STALL_W) ? STAGE + 1 : STALL_W - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_reg,     valid_next;
    logic [DATA_W-1:0] payload_reg,   payload_next;
    logic [31:0]       pc_reg,        pc_next;
    logic              delayslot_reg, delayslot_next;
    logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;
    logic [CNT_W-1:0]  hold_cnt_reg,   hold_cnt_next;

    logic up;
    logic dn;
    logic do_bubble;
    logic do_hold;

    assign up = stall[UP_IDX];
    assign dn = stall[DN_IDX];

    // Flush overrides every stall combination, so neither counter sees a
    // flush cycle. A non-monotone vector (up=0, dn=1) falls into advance.
    assign do_bubble = !flush && up && !dn;
    assign do_hold   = !flush && up && dn;

    // Next-state selection for the carried fields: flush, bubble, advance, hold.
    always_comb begin
        valid_next     = valid_reg;
        payload_next   = payload_reg;
        pc_next        = pc_reg;
        delayslot_next = delayslot_reg;
        if (flush) begin
            valid_next     = 1'b0;
            payload_next   = NOP_PAYLOAD;
            pc_next        = 32'h0;
            delayslot_next = 1'b0;
        end else if (!up) begin
            // All fields move together so nothing is left stale.
            valid_next     = in_valid;
            payload_next   = in_payload;
            pc_next        = in_pc;
            delayslot_next = in_delayslot;
        end else if (!dn) begin
            valid_next     = 1'b0;
            pc_next        = 32'h0;
            delayslot_next = 1'b0;
            // With clearing disabled the old payload lingers; consumers must
            // gate their write-enables with out_valid.
            if (CLEAR_ON_BUBBLE) begin
                payload_next = NOP_PAYLOAD;
            end
        end
    end

    // Saturating performance counters; a clear beats an increment.
    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        if (cnt_clr) begin
            bubble_cnt_next = '0;
            hold_cnt_next   = '0;
        end else begin
            if (do_bubble && (bubble_cnt_reg != CNT_MAX)) begin
                bubble_cnt_next = bubble_cnt_reg + 1'b1;
            end
            if (do_hold && (hold_cnt_reg != CNT_MAX)) begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
            end
        end
    end

    // Register all state; reset is asynchronous and takes effect without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg      <= 1'b0;
            payload_reg    <= NOP_PAYLOAD;
            pc_reg         <= 32'h0;
            delayslot_reg  <= 1'b0;
            bubble_cnt_reg <= '0;
            hold_cnt_reg   <= '0;
        end else begin
            valid_reg      <= valid_next;
            payload_reg    <= payload_next;
            pc_reg         <= pc_next;
            delayslot_reg  <= delayslot_next;
            bubble_cnt_reg <= bubble_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    assign out_valid     = valid_reg;
    assign out_payload   = payload_reg;
    assign out_pc        = pc_reg;
    assign out_delayslot = delayslot_reg;
    assign bubble_cnt    = bubble_cnt_reg;
    assign hold_cnt      = hold_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three pipe_stage_reg instances sharing one stimulus.
//   u_a: CLEAR_ON_BUBBLE=1, NOP=0,            CNT_W=16
//   u_b: CLEAR_ON_BUBBLE=0, NOP=A5A5...,      CNT_W=16
//   u_c: CLEAR_ON_BUBBLE=1, NOP=0,            CNT_W=4
// Directed steps follow the test plan, then a randomized phase; every cycle
// all outputs of all instances are compared with a behavioural model.
module tb_pipe_stage_reg;

    localparam logic [63:0] NOP_B = 64'hA5A5_A5A5_5A5A_5A5A;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cnt_clr;
    logic        in_valid;
    logic [63:0] in_payload;
    logic [31:0] in_pc;
    logic        in_delayslot;

    logic        a_valid, b_valid, c_valid;
    logic [63:0] a_payload, b_payload, c_payload;
    logic [31:0] a_pc, b_pc, c_pc;
    logic        a_ds, b_ds, c_ds;
    logic [15:0] a_bcnt, a_hcnt, b_bcnt, b_hcnt;
    logic [3:0]  c_bcnt, c_hcnt;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state, one entry per instance.
    logic        m_valid   [3];
    logic [63:0] m_payload [3];
    logic [31:0] m_pc      [3];
    logic        m_ds      [3];
    int          m_bcnt    [3];
    int          m_hcnt    [3];

    bit          p_clear   [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] p_nop     [3] = '{64'h0, NOP_B, 64'h0};
    int          p_max     [3] = '{65535, 65535, 15};

    pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(2), .NOP_PAYLOAD(64'h0),
                     .CLEAR_ON_BUBBLE(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc), .in_delayslot(in_delayslot),
        .out_valid(a_valid), .out_payload(a_payload), .out_pc(a_pc), .out_delayslot(a_ds),
        .bubble_cnt(a_bcnt), .hold_cnt(a_hcnt));

    pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(2), .NOP_PAYLOAD(NOP_B),
                     .CLEAR_ON_BUBBLE(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc), .in_delayslot(in_delayslot),
        .out_valid(b_valid), .out_payload(b_payload), .out_pc(b_pc), .out_delayslot(b_ds),
        .bubble_cnt(b_bcnt), .hold_cnt(b_hcnt));

    pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(2), .NOP_PAYLOAD(64'h0),
                     .CLEAR_ON_BUBBLE(1'b1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc), .in_delayslot(in_delayslot),
        .out_valid(c_valid), .out_payload(c_payload), .out_pc(c_pc), .out_delayslot(c_ds),
        .bubble_cnt(c_bcnt), .hold_cnt(c_hcnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is edge-driven, but never let it hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0; m_payload[i] = p_nop[i]; m_pc[i] = 32'h0; m_ds[i] = 1'b0;
            m_bcnt[i] = 0; m_hcnt[i] = 0;
        end
    endtask

    // One clock edge worth of the stage-register rules, per instance.
    task automatic model_step();
        bit upper_stalled, lower_stalled, is_bubble, is_hold;
        upper_stalled = stall[2];
        lower_stalled = stall[3];
        is_bubble = !flush && upper_stalled && !lower_stalled;
        is_hold   = !flush && upper_stalled && lower_stalled;
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                m_valid[i] = 1'b0; m_payload[i] = p_nop[i]; m_pc[i] = 32'h0; m_ds[i] = 1'b0;
            end else if (!upper_stalled) begin
                m_valid[i] = in_valid; m_payload[i] = in_payload; m_pc[i] = in_pc; m_ds[i] = in_delayslot;
            end else if (is_bubble) begin
                m_valid[i] = 1'b0; m_pc[i] = 32'h0; m_ds[i] = 1'b0;
                if (p_clear[i]) m_payload[i] = p_nop[i];
            end
            if (cnt_clr) begin
                m_bcnt[i] = 0;
                m_hcnt[i] = 0;
            end else begin
                if (is_bubble) m_bcnt[i] = (m_bcnt[i] + 1 > p_max[i]) ? p_max[i] : m_bcnt[i] + 1;
                if (is_hold)   m_hcnt[i] = (m_hcnt[i] + 1 > p_max[i]) ? p_max[i] : m_hcnt[i] + 1;
            end
        end
    endtask

    task automatic check_all(input string step);
        check({step, " a.valid"},   {63'h0, a_valid},   {63'h0, m_valid[0]});
        check({step, " a.payload"}, a_payload,          m_payload[0]);
        check({step, " a.pc"},      {32'h0, a_pc},      {32'h0, m_pc[0]});
        check({step, " a.ds"},      {63'h0, a_ds},      {63'h0, m_ds[0]});
        check({step, " a.bcnt"},    {48'h0, a_bcnt},    64'(m_bcnt[0]));
        check({step, " a.hcnt"},    {48'h0, a_hcnt},    64'(m_hcnt[0]));
        check({step, " b.valid"},   {63'h0, b_valid},   {63'h0, m_valid[1]});
        check({step, " b.payload"}, b_payload,          m_payload[1]);
        check({step, " b.pc"},      {32'h0, b_pc},      {32'h0, m_pc[1]});
        check({step, " b.ds"},      {63'h0, b_ds},      {63'h0, m_ds[1]});
        check({step, " b.bcnt"},    {48'h0, b_bcnt},    64'(m_bcnt[1]));
        check({step, " b.hcnt"},    {48'h0, b_hcnt},    64'(m_hcnt[1]));
        check({step, " c.valid"},   {63'h0, c_valid},   {63'h0, m_valid[2]});
        check({step, " c.payload"}, c_payload,          m_payload[2]);
        check({step, " c.pc"},      {32'h0, c_pc},      {32'h0, m_pc[2]});
        check({step, " c.ds"},      {63'h0, c_ds},      {63'h0, m_ds[2]});
        check({step, " c.bcnt"},    {60'h0, c_bcnt},    64'(m_bcnt[2]));
        check({step, " c.hcnt"},    {60'h0, c_hcnt},    64'(m_hcnt[2]));
    endtask

    // Advance one clock with the currently driven inputs, then compare.
    task automatic cycle(input string step);
        assert (!(stall[3] && !stall[2])) else
            $error("FAIL stall_vector non-monotone stimulus %b", stall);
        @(posedge clk);
        model_step();
        #1;
        check_all(step);
    endtask

    task automatic drive(input logic [5:0] s, input logic f, input logic clr, input logic v,
                         input logic [63:0] p, input logic [31:0] pc, input logic ds);
        stall = s; flush = f; cnt_clr = clr; in_valid = v; in_payload = p; in_pc = pc; in_delayslot = ds;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string step);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_all(step);
        #2 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(6'b000000, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        model_reset();
        #12;
        check_all("reset_initial");
        rst = 1'b1;

        // Load a live instruction, then reset mid-cycle without a clock edge.
        drive(6'b000000, 1'b0, 1'b0, 1'b1, 64'hDEAD, 32'h8000_0040, 1'b1);
        cycle("load_dead");
        drive(6'b000111, 1'b0, 1'b0, 1'b1, 64'hBEEF, 32'h8000_0044, 1'b0);
        cycle("bubble_before_reset");
        async_reset("reset_async");
        check("reset_async a.valid_const", {63'h0, a_valid}, 64'h0);
        check("reset_async b.payload_const", b_payload, NOP_B);

        // Advance.
        drive(6'b000000, 1'b0, 1'b0, 1'b1, 64'h1234, 32'hBFC0_0010, 1'b1);
        cycle("advance");
        check("advance a.payload_const", a_payload, 64'h1234);
        check("advance a.pc_const", {32'h0, a_pc}, 64'hBFC0_0010);

        // Bubble for three cycles.
        drive(6'b000111, 1'b0, 1'b0, 1'b1, 64'h5555, 32'h1111_2222, 1'b1);
        for (int k = 0; k < 3; k++) cycle($sformatf("bubble_%0d", k));
        check("bubble a.bcnt_const", {48'h0, a_bcnt}, 64'd3);
        check("bubble b.payload_kept", b_payload, 64'h1234);
        check("bubble a.payload_cleared", a_payload, 64'h0);

        // Re-load, then hold five cycles while the input keeps changing.
        drive(6'b000000, 1'b0, 1'b0, 1'b1, 64'h7777, 32'hBFC0_0020, 1'b0);
        cycle("reload");
        for (int k = 0; k < 5; k++) begin
            drive(6'b001111, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, $urandom, 1'($urandom));
            cycle($sformatf("hold_%0d", k));
        end
        check("hold a.hcnt_const", {48'h0, a_hcnt}, 64'd5);
        check("hold a.payload_frozen", a_payload, 64'h7777);

        // Flush beats hold.
        drive(6'b001111, 1'b1, 1'b0, 1'b1, 64'h9999, 32'hDEAD_BEEF, 1'b1);
        cycle("flush_over_hold");
        drive(6'b000111, 1'b1, 1'b0, 1'b1, 64'h9999, 32'hDEAD_BEEF, 1'b1);
        cycle("flush_over_bubble");

        // Saturation of the 4-bit counters, then clear racing a bubble.
        drive(6'b000111, 1'b0, 1'b0, 1'b1, 64'h4242, 32'h0000_4242, 1'b0);
        for (int k = 0; k < 20; k++) cycle($sformatf("sat_%0d", k));
        check("sat c.bcnt_const", {60'h0, c_bcnt}, 64'd15);
        drive(6'b001111, 1'b0, 1'b0, 1'b1, 64'h4242, 32'h0000_4242, 1'b0);
        for (int k = 0; k < 20; k++) cycle($sformatf("sat_hold_%0d", k));
        check("sat c.hcnt_const", {60'h0, c_hcnt}, 64'd15);
        drive(6'b000111, 1'b0, 1'b1, 1'b1, 64'h4242, 32'h0000_4242, 1'b0);
        cycle("clr_vs_bubble");
        check("clr c.bcnt_const", {60'h0, c_bcnt}, 64'd0);

        // Randomized phase with monotone stall vectors.
        for (int n = 0; n < 600; n++) begin
            int k;
            k = $urandom_range(0, 6);
            drive(6'((1 << k) - 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                  1'($urandom), {$urandom, $urandom}, $urandom, 1'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset($sformatf("rand_reset_%0d", n));
            else cycle($sformatf("rand_%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
